pipeline_mem_ctrl: RTL

- Sequencing controller for the 5-stage RV64I pipeline: F, D, E, M, W.
- Owns the single external memory port and shares it between I-cache refills and D-cache write-back/refills.
- Generates all per-stage stall and flush signals, covering cache misses, load-use hazards and taken jumps/branches.
- Consumes the main decoder's load-instruction flag as registered into the E stage.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/hazard_unit.sv | 59 +++++
 rtl/pipeline_mem_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline memory-port sequencer: FSM state encoding
// and memory-port owner identifiers.
package pipeline_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        D_WB_REQ = 3'd1,
        D_WB     = 3'd2,
        D_RD_REQ = 3'd3,
        D_RD     = 3'd4,
        I_RD_REQ = 3'd5,
        I_RD     = 3'd6,
        DONE     = 3'd7
    } t_mem_state;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    function automatic logic is_req_state(input t_mem_state s);
        return (s == D_WB_REQ) || (s == D_RD_REQ) || (s == I_RD_REQ);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational stall/flush resolution for load-use hazards and taken
// branches, with overrides from the memory sequencer's cache activity.
module hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_d_active,
    input  logic                  i_i_active,
    input  logic                  i_load_instr_e,
    input  logic [REG_ADDR_W-1:0] i_rd_e,
    input  logic [REG_ADDR_W-1:0] i_rs1_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_d,
    input  logic                  i_pc_src_e,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_stall_e,
    output logic                  o_stall_m,
    output logic                  o_stall_w,
    output logic                  o_flush_d,
    output logic                  o_flush_e
);

    logic load_use;

    always_comb begin
        load_use = i_load_instr_e && (i_rd_e != '0) &&
                   ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

        o_stall_f = 1'b0;
        o_stall_d = 1'b0;
        o_stall_e = 1'b0;
        o_stall_m = 1'b0;
        o_stall_w = 1'b0;
        o_flush_d = 1'b0;
        o_flush_e = 1'b0;

        // A frozen M stage must keep E intact, so no flush may slip through.
        if (i_d_active) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_stall_m = 1'b1;
            o_stall_w = 1'b1;
        end else begin
            o_stall_f = i_i_active;
            o_flush_d = i_i_active;
            if (i_pc_src_e) begin
                o_flush_d = 1'b1;
                o_flush_e = 1'b1;
            end else if (load_use) begin
                // D holds the dependent instruction, so it must not be bubbled.
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_flush_e = 1'b1;
                o_flush_d = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_mem_ctrl.sv
// Memory-port sequencer for the 5-stage pipeline: arbitrates I/D cache line
// bursts on one external port and produces all per-stage stall/flush signals.
module pipeline_mem_ctrl
    import pipeline_pkg::*;
#(
    parameter int BEATS      = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic                     i_icache_miss,
    input  logic                     i_dcache_miss,
    input  logic                     i_dcache_dirty,
    input  logic                     i_load_instr_e,
    input  logic [REG_ADDR_W-1:0]    i_rd_e,
    input  logic [REG_ADDR_W-1:0]    i_rs1_d,
    input  logic [REG_ADDR_W-1:0]    i_rs2_d,
    input  logic                     i_pc_src_e,
    input  logic                     i_mem_ready,
    input  logic                     i_mem_valid,
    output logic                     o_mem_req,
    output logic                     o_mem_we,
    output logic                     o_mem_sel,
    output logic [$clog2(BEATS)-1:0] o_beat,
    output logic                     o_icache_fill,
    output logic                     o_dcache_fill,
    output logic                     o_stall_f,
    output logic                     o_stall_d,
    output logic                     o_stall_e,
    output logic                     o_stall_m,
    output logic                     o_stall_w,
    output logic                     o_flush_d,
    output logic                     o_flush_e
);

    localparam int BEAT_W = $clog2(BEATS);

    t_mem_state        state_q;
    logic [BEAT_W-1:0] beat_q;
    logic              owner_q;
    logic              req_q;
    logic              we_q;

    logic last_beat;
    logic busy;
    logic d_active;
    logic i_active;

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            owner_q <= OWNER_I;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The M-stage instruction is older, so D wins a tie.
                    if (i_dcache_miss) begin
                        owner_q <= OWNER_D;
                        req_q   <= 1'b1;
                        we_q    <= i_dcache_dirty;
                        state_q <= i_dcache_dirty ? D_WB_REQ : D_RD_REQ;
                    end else if (i_icache_miss) begin
                        owner_q <= OWNER_I;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        state_q <= I_RD_REQ;
                    end
                end
                D_WB_REQ, D_RD_REQ, I_RD_REQ: begin
                    if (i_mem_ready) begin
                        req_q   <= 1'b0;
                        state_q <= (state_q == D_WB_REQ) ? D_WB :
                                   (state_q == D_RD_REQ) ? D_RD : I_RD;
                    end
                end
                D_WB, D_RD, I_RD: begin
                    if (i_mem_valid) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            if (state_q == D_WB) begin
                                req_q   <= 1'b1;
                                we_q    <= 1'b0;
                                state_q <= D_RD_REQ;
                            end else begin
                                state_q <= DONE;
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_req = req_q;
    assign o_mem_we  = we_q;
    assign o_mem_sel = owner_q;
    assign o_beat    = beat_q;

    assign o_dcache_fill = i_arst && (state_q == D_RD) && i_mem_valid && last_beat;
    assign o_icache_fill = i_arst && (state_q == I_RD) && i_mem_valid && last_beat;

    // Miss inputs count in IDLE so the pipeline freezes in the miss cycle itself.
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign d_active = (busy && (owner_q == OWNER_D)) ||
                      ((state_q == IDLE) && i_dcache_miss);
    assign i_active = (busy && (owner_q == OWNER_I)) ||
                      ((state_q == IDLE) && i_icache_miss && !i_dcache_miss);

    logic hz_stall_f, hz_stall_d, hz_stall_e, hz_stall_m, hz_stall_w;
    logic hz_flush_d, hz_flush_e;

    hazard_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .i_d_active     (d_active),
        .i_i_active     (i_active),
        .i_load_instr_e (i_load_instr_e),
        .i_rd_e         (i_rd_e),
        .i_rs1_d        (i_rs1_d),
        .i_rs2_d        (i_rs2_d),
        .i_pc_src_e     (i_pc_src_e),
        .o_stall_f      (hz_stall_f),
        .o_stall_d      (hz_stall_d),
        .o_stall_e      (hz_stall_e),
        .o_stall_m      (hz_stall_m),
        .o_stall_w      (hz_stall_w),
        .o_flush_d      (hz_flush_d),
        .o_flush_e      (hz_flush_e)
    );

    assign o_stall_f = i_arst && hz_stall_f;
    assign o_stall_d = i_arst && hz_stall_d;
    assign o_stall_e = i_arst && hz_stall_e;
    assign o_stall_m = i_arst && hz_stall_m;
    assign o_stall_w = i_arst && hz_stall_w;
    assign o_flush_d = i_arst && hz_flush_d;
    assign o_flush_e = i_arst && hz_flush_e;

    a_req_only_in_req: assert property (@(posedge i_clk) disable iff (!i_arst)
        o_mem_req |-> is_req_state(state_q));
    a_fills_exclusive: assert property (@(posedge i_clk) disable iff (!i_arst)
        !(o_icache_fill && o_dcache_fill));
    a_flush_stall_excl: assert property (@(posedge i_clk) disable iff (!i_arst)
        !(o_flush_d && o_stall_d) && !(o_flush_e && o_stall_e));

endmodule
